aidc_lite_comp_select: RTL and testbench
========================================

AIDC_LITE_COMP_SELECT -- requirements
Module: AIDC_LITE_COMP_SELECT

Interface
REQ-001 Parameter BUF_AW, default 4, is the compressor-buffer address width (16 x 64-bit entries = one 128-byte block).
REQ-002 Parameter LEN_W, default 5, is the length field width in 64-bit words (0..16).
REQ-003 clk  input  1  single clock, all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 sop_i  input  1  start of a new 128-byte block; clears all selection state.
REQ-006 compN_done_i (N=0..2)  input  1  compressor N finished; level, held until next sop_i.
REQ-007 compN_fail_i  input  1  compressor N output unusable; valid while compN_done_i=1.
REQ-008 compN_len_i  input  LEN_W  compressed length of N in 64-bit words; valid while compN_done_i=1.
REQ-009 raddr_o  output  BUF_AW  read address broadcast to all three compressor buffers.
REQ-010 bufN_rdata_i  input  64  buffer N read data; reflects raddr_o of the previous cycle.
REQ-011 ready_o  output  1  rdata_o holds a valid 32-bit word.
REQ-012 rden_i  input  1  engine pops rdata_o; effective only when ready_o=1.
REQ-013 rdata_o  output  32  output word stream: header, then payload.
REQ-014 sel_o  output  2  selected algorithm: 0=SR, 1=ZRLE, 2=BPC, 3=RAW (all failed).
REQ-015 busy_o  output  1  high from selection until last word popped.

Function
REQ-016 FSM states IDLE, HDR, FETCH, LO, HI; FSM SHALL leave IDLE the cycle after all three compN_done_i are sampled high.
REQ-017 Selection: smallest compN_len_i among non-failed N; ties to lowest N; all failed -> sel=3, len=0; registered on IDLE->HDR.
REQ-018 A non-failed compressor with len >= 16 SHALL be treated as failed.
REQ-019 Header word: [31:30]=sel, [LEN_W-1:0]=len, all other bits 0.
REQ-020 HDR: ready_o=1, rdata_o=header, raddr_o=0; on pop: len=0 -> IDLE, else -> FETCH.
REQ-021 FETCH: ready_o=0, exactly one cycle, -> LO.
REQ-022 LO: ready_o=1, rdata_o=bufSEL_rdata_i[31:0]; pop -> HI.
REQ-023 HI: ready_o=1, rdata_o=bufSEL_rdata_i[63:32]; pop -> raddr_o+1 with FETCH if words remain, else IDLE.
REQ-024 Words per block = 1 + 2*len; throughput one word/cycle except one FETCH bubble per 64-bit entry.
REQ-025 rden_i with ready_o=0 SHALL be ignored; without rden_i, state and rdata_o hold indefinitely.
REQ-026 rdata_o SHALL be 0 whenever ready_o=0.
REQ-027 sop_i in any state SHALL force IDLE next cycle, drop ready_o/busy_o, and win over a simultaneous rden_i.
REQ-028 Done levels not all high: FSM stays IDLE; done seen with sop_i same cycle: sop_i wins.

Reset
REQ-029 rst_n low SHALL asynchronously force IDLE, ready_o=0, rdata_o=0, raddr_o=0, sel_o=0, busy_o=0, stored len=0.
REQ-030 After rst_n deassertion, no output SHALL change until all compN_done_i are high.

Structure
REQ-031 Shared package holds algorithm-id constants (SR, ZRLE, BPC, RAW), BUF_AW, LEN_W, and the FSM state enum.
REQ-032 One sub-module AIDC_LITE_COMP_ARGMIN: combinational 3-way min-length/priority selector returning sel and len.

Verification
REQ-033 len={3,5,2}, no fails, rden_i held 1 -> header 0x8000_0002, then buf2 entries 0,1 lo/hi, FETCH bubble before each entry, IDLE.
REQ-034 len={4,4,9}, comp0 fail -> sel=1, header 0x4000_0004, 8 payload words from buf1 addresses 0..3.
REQ-035 All fail -> single header 0xC000_0000, busy_o low after that pop, raddr_o stays 0.
REQ-036 Engine stalls (rden_i=0) 10 cycles in LO -> rdata_o and raddr_o stable; resume pops correct hi half.
REQ-037 sop_i asserted in HI with rden_i=1 -> next cycle IDLE, ready_o=0, rdata_o=0; new block re-selects correctly.
REQ-038 rst_n pulsed low mid-stream asynchronously -> all outputs at reset values before next clock edge.

Source files
------------

// File: rtl/aidc_lite_comp_select_pkg.sv
// Shared definitions for the compressor-select block.
//   BUF_AW / LEN_W : default buffer address width and length field width
//   alg_e          : algorithm identifiers carried in sel_o and the header
//   state_e        : output-stream FSM states
package aidc_lite_comp_select_pkg;

  localparam int unsigned BUF_AW = 4;
  localparam int unsigned LEN_W  = 5;

  typedef enum logic [1:0] {
    ALG_SR   = 2'd0,
    ALG_ZRLE = 2'd1,
    ALG_BPC  = 2'd2,
    ALG_RAW  = 2'd3
  } alg_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_FETCH,
    ST_LO,
    ST_HI
  } state_e;

endpackage

// File: rtl/aidc_lite_comp_select_argmin.sv
// Combinational 3-way selector: picks the shortest usable compressor output.
//   fail       : per-compressor unusable flag
//   len0..len2 : compressed lengths in 64-bit words
//   sel        : winning algorithm id (ALG_RAW when none is usable)
//   len        : winning length (0 when none is usable)
module aidc_lite_comp_select_argmin #(
  parameter int unsigned BUF_AW = aidc_lite_comp_select_pkg::BUF_AW,
  parameter int unsigned LEN_W  = aidc_lite_comp_select_pkg::LEN_W
) (
  input  logic [2:0]       fail,
  input  logic [LEN_W-1:0] len0,
  input  logic [LEN_W-1:0] len1,
  input  logic [LEN_W-1:0] len2,
  output logic [1:0]       sel,
  output logic [LEN_W-1:0] len
);
  import aidc_lite_comp_select_pkg::*;

  // An output that fills the whole buffer saves nothing; treat it as failed.
  localparam int unsigned MAX_LEN = 1 << BUF_AW;

  logic [2:0][LEN_W-1:0] lens;
  logic                  found;

  assign lens = {len2, len1, len0};

  // Strict '<' keeps the lowest index on ties.
  always_comb begin
    sel   = ALG_RAW;
    len   = '0;
    found = 1'b0;
    for (int unsigned n = 0; n < 3; n++) begin
      if (!fail[n] && (32'(lens[n]) < MAX_LEN) && (!found || (lens[n] < len))) begin
        found = 1'b1;
        sel   = 2'(n);
        len   = lens[n];
      end
    end
  end

endmodule

// File: rtl/aidc_lite_comp_select.sv
// Chooses the best of three compressor results for a 128-byte block and
// streams a header word followed by the chosen buffer as 32-bit words.
//   clk, rst_n           : clock, asynchronous active-low reset
//   sop_i                : start of block, clears all selection state
//   compN_done/fail/len  : per-compressor completion, failure and length
//   raddr_o              : read address shared by the three buffers
//   bufN_rdata_i         : buffer data for the previous cycle's raddr_o
//   ready_o/rden_i       : output word valid / consumer pop
//   rdata_o              : header then payload words (0 when not ready)
//   sel_o                : selected algorithm
//   busy_o               : block selected and not yet fully popped
module aidc_lite_comp_select #(
  parameter int unsigned BUF_AW = aidc_lite_comp_select_pkg::BUF_AW,
  parameter int unsigned LEN_W  = aidc_lite_comp_select_pkg::LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sop_i,
  input  logic              comp0_done_i,
  input  logic              comp0_fail_i,
  input  logic [LEN_W-1:0]  comp0_len_i,
  input  logic              comp1_done_i,
  input  logic              comp1_fail_i,
  input  logic [LEN_W-1:0]  comp1_len_i,
  input  logic              comp2_done_i,
  input  logic              comp2_fail_i,
  input  logic [LEN_W-1:0]  comp2_len_i,
  output logic [BUF_AW-1:0] raddr_o,
  input  logic [63:0]       buf0_rdata_i,
  input  logic [63:0]       buf1_rdata_i,
  input  logic [63:0]       buf2_rdata_i,
  output logic              ready_o,
  input  logic              rden_i,
  output logic [31:0]       rdata_o,
  output logic [1:0]        sel_o,
  output logic              busy_o
);
  import aidc_lite_comp_select_pkg::*;

  state_e           state;
  logic             armed;
  logic [LEN_W-1:0] len_q;
  logic [1:0]       arg_sel;
  logic [LEN_W-1:0] arg_len;
  logic             all_done;
  logic             last_entry;
  logic [63:0]      buf_data;
  logic [31:0]      header;

  aidc_lite_comp_select_argmin #(
    .BUF_AW (BUF_AW),
    .LEN_W  (LEN_W)
  ) u_argmin (
    .fail ({comp2_fail_i, comp1_fail_i, comp0_fail_i}),
    .len0 (comp0_len_i),
    .len1 (comp1_len_i),
    .len2 (comp2_len_i),
    .sel  (arg_sel),
    .len  (arg_len)
  );

  assign all_done   = comp0_done_i & comp1_done_i & comp2_done_i;
  assign last_entry = (32'(raddr_o) + 32'd1) == 32'(len_q);

  always_comb begin
    case (sel_o)
      2'd0:    buf_data = buf0_rdata_i;
      2'd1:    buf_data = buf1_rdata_i;
      2'd2:    buf_data = buf2_rdata_i;
      default: buf_data = '0;
    endcase
  end

  always_comb begin
    header              = '0;
    header[31:30]       = sel_o;
    header[LEN_W-1:0]   = len_q;
  end

  // Payload comes straight from the buffer read port; the FETCH bubble gives
  // the buffer one cycle to present the entry at the new address.
  always_comb begin
    case (state)
      ST_HDR:  rdata_o = header;
      ST_LO:   rdata_o = buf_data[31:0];
      ST_HI:   rdata_o = buf_data[63:32];
      default: rdata_o = '0;
    endcase
  end

  // Done levels stay high after the block is streamed, so 'armed' limits
  // selection to once per sop_i (or reset).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      armed   <= 1'b1;
      len_q   <= '0;
      raddr_o <= '0;
      sel_o   <= '0;
      ready_o <= 1'b0;
      busy_o  <= 1'b0;
    end else if (sop_i) begin
      state   <= ST_IDLE;
      armed   <= 1'b1;
      len_q   <= '0;
      raddr_o <= '0;
      sel_o   <= '0;
      ready_o <= 1'b0;
      busy_o  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (armed && all_done) begin
            state   <= ST_HDR;
            armed   <= 1'b0;
            sel_o   <= arg_sel;
            len_q   <= arg_len;
            raddr_o <= '0;
            ready_o <= 1'b1;
            busy_o  <= 1'b1;
          end
        end
        ST_HDR: begin
          if (rden_i) begin
            ready_o <= 1'b0;
            if (len_q == '0) begin
              state  <= ST_IDLE;
              busy_o <= 1'b0;
            end else begin
              state <= ST_FETCH;
            end
          end
        end
        ST_FETCH: begin
          state   <= ST_LO;
          ready_o <= 1'b1;
        end
        ST_LO: begin
          if (rden_i) state <= ST_HI;
        end
        ST_HI: begin
          if (rden_i) begin
            ready_o <= 1'b0;
            if (last_entry) begin
              state  <= ST_IDLE;
              busy_o <= 1'b0;
            end else begin
              state   <= ST_FETCH;
              raddr_o <= raddr_o + 1'b1;
            end
          end
        end
        default: begin
          state   <= ST_IDLE;
          ready_o <= 1'b0;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aidc_lite_comp_select.sv
module tb_aidc_lite_comp_select;

  typedef struct packed {
    logic        ready;
    logic        busy;
    logic [31:0] data;
    logic        ra_chk;
    logic [3:0]  raddr;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        sop;
  logic [2:0]  done;
  logic [2:0]  fail;
  logic [4:0]  len0, len1, len2;
  logic [3:0]  raddr;
  logic [63:0] buf0, buf1, buf2;
  logic        ready;
  logic        rden;
  logic [31:0] rdata;
  logic [1:0]  sel;
  logic        busy;

  logic [63:0] mem [3][16];
  exp_t        q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  aidc_lite_comp_select #(
    .BUF_AW (4),
    .LEN_W  (5)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sop_i        (sop),
    .comp0_done_i (done[0]),
    .comp0_fail_i (fail[0]),
    .comp0_len_i  (len0),
    .comp1_done_i (done[1]),
    .comp1_fail_i (fail[1]),
    .comp1_len_i  (len1),
    .comp2_done_i (done[2]),
    .comp2_fail_i (fail[2]),
    .comp2_len_i  (len2),
    .raddr_o      (raddr),
    .buf0_rdata_i (buf0),
    .buf1_rdata_i (buf1),
    .buf2_rdata_i (buf2),
    .ready_o      (ready),
    .rden_i       (rden),
    .rdata_o      (rdata),
    .sel_o        (sel),
    .busy_o       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Buffer models: registered read of the address presented last cycle.
  always_ff @(posedge clk) begin
    buf0 <= mem[0][raddr];
    buf1 <= mem[1][raddr];
    buf2 <= mem[2][raddr];
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic r, input logic b, input logic [31:0] d,
                      input logic rc, input logic [3:0] ra);
    exp_t e;
    e.ready = r; e.busy = b; e.data = d; e.ra_chk = rc; e.raddr = ra;
    q.push_back(e);
  endtask

  task automatic start_block(input logic [2:0] f, input logic [4:0] a, b, c);
    fail = f; len0 = a; len1 = b; len2 = c; done = 3'b111;
  endtask

  // Reference selection and expected per-cycle stream with rden held high.
  task automatic expect_block(input logic [2:0] f, input logic [4:0] a, b, c,
                              output logic [1:0] esel);
    logic [4:0] l [3];
    logic [4:0] elen;
    l[0] = a; l[1] = b; l[2] = c;
    esel = 2'd3; elen = 5'd0;
    for (int n = 0; n < 3; n++) begin
      if (!f[n] && l[n] < 5'd16 && (esel == 2'd3 || l[n] < elen)) begin
        esel = 2'(n); elen = l[n];
      end
    end
    push(1'b1, 1'b1, {esel, 25'b0, elen}, 1'b1, 4'd0);
    for (int e = 0; e < int'(elen); e++) begin
      push(1'b0, 1'b1, 32'h0, 1'b1, 4'(e));
      push(1'b1, 1'b1, mem[esel][e][31:0], 1'b1, 4'(e));
      push(1'b1, 1'b1, mem[esel][e][63:32], 1'b1, 4'(e));
    end
    push(1'b0, 1'b0, 32'h0, 1'b1, (elen == 5'd0) ? 4'd0 : 4'(elen - 5'd1));
  endtask

  task automatic step(input string tag, output exp_t e);
    @(negedge clk);
    if (q.size() == 0) begin
      e = '0;
      chk({tag, "_underflow"}, 64'd1, 64'd0);
    end else begin
      e = q.pop_front();
      chk({tag, "_rdy_busy_data"}, {30'b0, ready, busy, rdata}, {30'b0, e.ready, e.busy, e.data});
      if (e.ra_chk) chk({tag, "_raddr"}, {60'b0, raddr}, {60'b0, e.raddr});
    end
  endtask

  task automatic drain(input string tag);
    exp_t e;
    int n;
    n = q.size();
    for (int i = 0; i < n; i++) step(tag, e);
  endtask

  task automatic sop_cycle();
    exp_t e;
    sop = 1'b1; done = 3'b000;
    push(1'b0, 1'b0, 32'h0, 1'b0, 4'd0);
    step("sop", e);
    sop = 1'b0;
  endtask

  initial begin
    exp_t       e;
    exp_t       lo;
    logic [1:0] esel;

    for (int b = 0; b < 3; b++)
      for (int a = 0; a < 16; a++) mem[b][a] = {$urandom, $urandom};
    rst_n = 1'b1; sop = 1'b0; done = '0; fail = '0; rden = 1'b0;
    len0 = '0; len1 = '0; len2 = '0;
    #1 rst_n = 1'b0;
    #2;
    chk("reset_ready", {63'b0, ready}, 64'd0);
    chk("reset_rdata", {32'b0, rdata}, 64'd0);
    chk("reset_raddr", {60'b0, raddr}, 64'd0);
    chk("reset_sel",   {62'b0, sel},   64'd0);
    chk("reset_busy",  {63'b0, busy},  64'd0);
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Only two done levels: must stay idle.
    done = 3'b011; len0 = 5'd1; len1 = 5'd1; rden = 1'b1;
    repeat (3) push(1'b0, 1'b0, 32'h0, 1'b1, 4'd0);
    drain("partial_done");

    // Smallest length wins: buf2, 2 entries.
    start_block(3'b000, 5'd3, 5'd5, 5'd2);
    expect_block(3'b000, 5'd3, 5'd5, 5'd2, esel);
    step("blk_a_hdr", e);
    chk("blk_a_sel", {62'b0, sel}, {62'b0, esel});
    drain("blk_a");
    // Done levels still high: no restart without sop.
    repeat (3) push(1'b0, 1'b0, 32'h0, 1'b1, 4'd1);
    drain("held_done");

    // sop with done in the same cycle: sop wins, selection follows.
    sop = 1'b1; start_block(3'b001, 5'd4, 5'd4, 5'd9);
    push(1'b0, 1'b0, 32'h0, 1'b0, 4'd0);
    drain("sop_done_same");
    sop = 1'b0;
    expect_block(3'b001, 5'd4, 5'd4, 5'd9, esel);
    step("blk_b_hdr", e);
    chk("blk_b_sel", {62'b0, sel}, {62'b0, esel});
    drain("blk_b");

    // All failed: header only, raw.
    sop_cycle();
    start_block(3'b111, 5'd1, 5'd2, 5'd3);
    expect_block(3'b111, 5'd1, 5'd2, 5'd3, esel);
    step("blk_c_hdr", e);
    chk("blk_c_sel", {62'b0, sel}, {62'b0, esel});
    drain("blk_c");
    repeat (2) push(1'b0, 1'b0, 32'h0, 1'b1, 4'd0);
    drain("blk_c_idle");

    // len 16 counts as failed, tie goes to comp1; stall 10 cycles in LO.
    sop_cycle();
    start_block(3'b000, 5'd16, 5'd2, 5'd2);
    expect_block(3'b000, 5'd16, 5'd2, 5'd2, esel);
    step("blk_d_hdr", e);
    chk("blk_d_sel", {62'b0, sel}, {62'b0, esel});
    step("blk_d_fetch", e);
    step("blk_d_lo", lo);
    rden = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk("stall_out", {30'b0, ready, busy, rdata}, {30'b0, 1'b1, 1'b1, lo.data});
      chk("stall_raddr", {60'b0, raddr}, 64'd0);
    end
    rden = 1'b1;
    drain("blk_d");

    // sop during HI with rden high.
    sop_cycle();
    start_block(3'b000, 5'd6, 5'd3, 5'd4);
    expect_block(3'b000, 5'd6, 5'd3, 5'd4, esel);
    for (int i = 0; i < 4; i++) step("blk_e", e);
    q.delete();
    sop = 1'b1; done = 3'b000;
    push(1'b0, 1'b0, 32'h0, 1'b0, 4'd0);
    drain("sop_in_hi");
    sop = 1'b0;
    start_block(3'b100, 5'd5, 5'd9, 5'd1);
    expect_block(3'b100, 5'd5, 5'd9, 5'd1, esel);
    step("blk_f_hdr", e);
    chk("blk_f_sel", {62'b0, sel}, {62'b0, esel});
    drain("blk_f");

    // Usable zero-length result: header only.
    sop_cycle();
    start_block(3'b000, 5'd3, 5'd0, 5'd0);
    expect_block(3'b000, 5'd3, 5'd0, 5'd0, esel);
    step("blk_g_hdr", e);
    chk("blk_g_sel", {62'b0, sel}, {62'b0, esel});
    drain("blk_g");

    // Asynchronous reset mid-stream.
    sop_cycle();
    start_block(3'b000, 5'd2, 5'd2, 5'd2);
    expect_block(3'b000, 5'd2, 5'd2, 5'd2, esel);
    for (int i = 0; i < 3; i++) step("blk_h", e);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ready", {63'b0, ready}, 64'd0);
    chk("arst_rdata", {32'b0, rdata}, 64'd0);
    chk("arst_raddr", {60'b0, raddr}, 64'd0);
    chk("arst_sel",   {62'b0, sel},   64'd0);
    chk("arst_busy",  {63'b0, busy},  64'd0);
    done = 3'b000;
    q.delete();
    @(negedge clk) rst_n = 1'b1;
    repeat (2) push(1'b0, 1'b0, 32'h0, 1'b1, 4'd0);
    drain("post_arst_idle");
    start_block(3'b000, 5'd4, 5'd1, 5'd3);
    expect_block(3'b000, 5'd4, 5'd1, 5'd3, esel);
    step("blk_i_hdr", e);
    chk("blk_i_sel", {62'b0, sel}, {62'b0, esel});
    drain("blk_i");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
